// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record.
package regfile_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         idx
);
  logic       found;
  logic [3:0] best_d;
  logic [3:0] d;

  // Pick the valid requester with the smallest wrapped distance from ptr.
  always_comb begin
    grant  = '0;
    idx    = '0;
    found  = 1'b0;
    best_d = '1;
    d      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      d = (4'(i) >= {1'b0, ptr}) ? 4'(i) - {1'b0, ptr}
                                 : 4'(i) + 4'(NUM_REQ) - {1'b0, ptr};
      if (req[i] && (!found || d < best_d)) begin
        found  = 1'b1;
        best_d = d;
        idx    = 3'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant[i] = found && (idx == 3'(i));
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port, with a registered
// write stage and saturating commit/discard statistics.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter bit          DISCARD_R0 = 1'b1
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [2:0]                wr_src,
  output logic [15:0]               wr_count,
  output logic [7:0]                drop_count
);
  logic [2:0]         rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         grant_idx;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_r0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = (nrst && !stall) ? grant : '0;
  assign xfer      = |(req_ready & req_valid);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_r0 = DISCARD_R0 && (sel_addr == ADDR_W'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rr_ptr     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_src     <= '0;
      wr_count   <= '0;
      drop_count <= '0;
    end else if (xfer) begin
      rr_ptr  <= (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      wr_src  <= grant_idx;
      if (sel_r0) begin
        wr_en      <= 1'b0;
        drop_count <= (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
      end else begin
        wr_en    <= 1'b1;
        wr_count <= (wr_count == 16'hFFFF) ? wr_count : wr_count + 16'd1;
      end
    end else begin
      wr_en <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NUM_REQ=3, 5-bit addr, 32-bit data).
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        nrst;
  logic        stall;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  wr_src;
  logic [15:0] wr_count;
  logic [7:0]  drop_count;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32), .DISCARD_R0(1'b1)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_src     (wr_src),
    .wr_count   (wr_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with every requester valid
    nrst = 1'b0; stall = 1'b0; req_valid = 3'b111;
    req_addr = {5'd3, 5'd2, 5'd1};
    req_data = {32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_count", 32'(wr_count), 32'h0);
    chk("rst_drop_count", 32'(drop_count), 32'h0);

    // 2: single request from requester 1
    nrst = 1'b1; req_valid = 3'b010;
    req_addr = {5'd0, 5'd7, 5'd0};
    req_data = {32'h0, 32'hDEADBEEF, 32'h0};
    #1 chk("single_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b000;
    #1 chk("single_ready_drop", 32'(req_ready), 32'h0);
    chk("single_wr_en", 32'(wr_en), 32'h1);
    chk("single_wr_addr", 32'(wr_addr), 32'h7);
    chk("single_wr_data", wr_data, 32'hDEADBEEF);
    chk("single_wr_src", 32'(wr_src), 32'h1);
    chk("single_wr_count", 32'(wr_count), 32'h1);
    tick();
    chk("single_idle_wr_en", 32'(wr_en), 32'h0);
    chk("single_idle_hold_addr", 32'(wr_addr), 32'h7);

    // 3: contention from reset, expect 0,1,2,0,1,2 with wr_en every cycle
    nrst = 1'b0; tick();
    nrst = 1'b1; req_valid = 3'b111;
    req_addr = {5'd3, 5'd2, 5'd1};
    req_data = {32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("cont_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      if (k == 5) req_valid = 3'b000;
      chk($sformatf("cont_wr_en_%0d", k), 32'(wr_en), 32'h1);
      chk($sformatf("cont_wr_src_%0d", k), 32'(wr_src), 32'(k % 3));
      chk($sformatf("cont_wr_data_%0d", k), wr_data, 32'h1000_0000 + 32'(k % 3));
    end
    chk("cont_wr_count", 32'(wr_count), 32'd6);

    // 4: write to r0 is accepted but discarded (rr_ptr now 0)
    req_valid = 3'b001;
    req_addr = {5'd3, 5'd2, 5'd0};
    req_data = {32'h1000_0002, 32'h1000_0001, 32'h0000_1234};
    #1 chk("r0_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b000;
    chk("r0_wr_en", 32'(wr_en), 32'h0);
    chk("r0_drop_count", 32'(drop_count), 32'h1);
    chk("r0_wr_count", 32'(wr_count), 32'd6);

    // 5: stall with rr_ptr=1; requesters 0 and 2 valid -> grant must go to 2
    req_valid = 3'b101; stall = 1'b1;
    req_addr = {5'd9, 5'd0, 5'd4};
    req_data = {32'hCAFE_0009, 32'h0, 32'hCAFE_0004};
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall_ready_%0d", k), 32'(req_ready), 32'h0);
      tick();
      chk($sformatf("stall_wr_en_%0d", k), 32'(wr_en), 32'h0);
    end
    stall = 1'b0;
    #1 chk("unstall_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 3'b000;
    chk("unstall_wr_en", 32'(wr_en), 32'h1);
    chk("unstall_wr_src", 32'(wr_src), 32'h2);
    chk("unstall_wr_addr", 32'(wr_addr), 32'd9);
    chk("unstall_wr_data", wr_data, 32'hCAFE_0009);
    chk("unstall_wr_count", 32'(wr_count), 32'd7);

    // staged write completes under stall, then wr_en drops
    req_valid = 3'b001;
    tick();
    stall = 1'b1;
    #1 chk("stall_stage_ready", 32'(req_ready), 32'h0);
    chk("stall_stage_wr_en", 32'(wr_en), 32'h1);
    tick();
    chk("stall_stage_drop", 32'(wr_en), 32'h0);
    chk("stall_stage_count", 32'(wr_count), 32'd8);
    stall = 1'b0;

    // 6: saturate wr_count, then reset the cycle after a transfer
    for (int k = 0; k < 65540; k++) tick();
    chk("sat_wr_count", 32'(wr_count), 32'hFFFF);
    chk("sat_wr_en", 32'(wr_en), 32'h1);
    nrst = 1'b0;
    #1 chk("midrst_ready", 32'(req_ready), 32'h0);
    tick();
    chk("midrst_wr_en", 32'(wr_en), 32'h0);
    chk("midrst_wr_count", 32'(wr_count), 32'h0);
    chk("midrst_drop_count", 32'(drop_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
